// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: producer/consumer handshake and status bundle for fifo_sync_flags
interface fifo_sync_flags_if #(parameter int DATA_W = 8, parameter int ADDR_W = 4);
  logic wr;
  logic rd;
  logic clr_err;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic overflow;
  logic underflow;
  logic [ADDR_W:0] count;
  modport master (
    output wr, wr_data, rd, clr_err,
    input rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input wr, wr_data, rd, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with count, threshold and sticky error flags; FIFO_REG_OUT_EN registers rd_data
module fifo_sync_flags #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input logic clk,
  input logic reset,
  fifo_sync_flags_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic overflow;
  logic underflow;
  logic wr_ok;
  logic rd_ok;
  assign wr_ok = bus.wr & (~bus.full | bus.rd);
  assign rd_ok = bus.rd & ~bus.empty;
  assign bus.count = count;
  assign bus.full = count == (ADDR_W+1)'(DEPTH);
  assign bus.empty = count == '0;
  assign bus.almost_full = count >= (ADDR_W+1)'(AF_LEVEL);
  assign bus.almost_empty = count <= (ADDR_W+1)'(AE_LEVEL);
  assign bus.overflow = overflow;
  assign bus.underflow = underflow;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= (wr_ok & ~rd_ok) ? count + (ADDR_W+1)'(1) :
               (rd_ok & ~wr_ok) ? count - (ADDR_W+1)'(1) : count;
      // a new error event wins over a clear in the same cycle
      overflow <= (bus.wr & bus.full & ~bus.rd) | (overflow & ~bus.clr_err);
      underflow <= (bus.rd & bus.empty) | (underflow & ~bus.clr_err);
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= bus.wr_data;
`ifdef FIFO_REG_OUT_EN
  logic [DATA_W-1:0] rd_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) rd_q <= '0;
    else if (rd_ok) rd_q <= mem[rd_ptr];
  assign bus.rd_data = rd_q;
`else
  assign bus.rd_data = mem[rd_ptr];
`endif
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: scoreboard bench for fifo_sync_flags in show-ahead or registered-output build
module tb_fifo_sync_flags;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];
  logic m_ov = 1'b0;
  logic m_uf = 1'b0;
  fifo_sync_flags_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  fifo_sync_flags #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] exp_flags();
    int sz = q.size();
    return {sz == 16, sz == 0, sz >= 12, sz <= 2, m_ov, m_uf};
  endfunction
  function automatic logic [5:0] dut_flags();
    return {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow};
  endfunction
  // one clock: drive, model, step past the edge, compare data/count/flags
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic clr);
    logic [7:0] seen;
    logic [7:0] exp;
    logic pop;
    logic push;
    logic set_ov;
    logic set_uf;
    bus.wr = w;
    bus.wr_data = d;
    bus.rd = r;
    bus.clr_err = clr;
    pop = r && q.size() > 0;
    push = w && (q.size() < 16 || r);
    set_ov = w && q.size() == 16 && !r;
    set_uf = r && q.size() == 0;
    #1;
    seen = bus.rd_data;
    @(posedge clk);
    #1;
`ifdef FIFO_REG_OUT_EN
    seen = bus.rd_data;
`endif
    if (pop) begin
      exp = q.pop_front();
      tests++;
      if (seen !== exp) begin
        fails++;
        $display("FAIL rd_data: got %0h expected %0h", seen, exp);
      end
    end
    if (push) q.push_back(d);
    m_ov = set_ov | (m_ov & ~clr);
    m_uf = set_uf | (m_uf & ~clr);
    tests++;
    if (bus.count !== 5'(q.size())) begin
      fails++;
      $display("FAIL count: got %0d expected %0d", bus.count, q.size());
    end
    tests++;
    if (dut_flags() !== exp_flags()) begin
      fails++;
      $display("FAIL flags(f,e,af,ae,ov,uf): got %b expected %b", dut_flags(), exp_flags());
    end
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.clr_err = 1'b0;
  endtask
  task automatic check_reset_state(input string tag);
    tests++;
    if (bus.count !== 5'd0 || dut_flags() !== 6'b010100) begin
      fails++;
      $display("FAIL %s: got count %0d flags %b expected count 0 flags 010100", tag, bus.count, dut_flags());
    end
`ifdef FIFO_REG_OUT_EN
    tests++;
    if (bus.rd_data !== 8'h00) begin
      fails++;
      $display("FAIL %s rd_data: got %0h expected 0", tag, bus.rd_data);
    end
`endif
  endtask
  task automatic test_reset();
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.clr_err = 1'b0;
    bus.wr_data = '0;
    #12;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("after_release");
  endtask
  task automatic test_fill();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
  endtask
  task automatic test_drain();
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    test_drain();
  endtask
  task automatic test_underflow();
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      fails++;
      $display("FAIL clr_err: got ov %b uf %b expected 0 0", bus.overflow, bus.underflow);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45), 1'b1);
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    m_ov = 1'b0;
    m_uf = 1'b0;
    check_reset_state("reset_mid");
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
